arbiter_rr_32: RTL
==================

ARBITER_RR_32 -- requirements
Module: arbiter_rr_32

Interface
REQ-001 The module SHALL have parameter MAX_HOLD, default 16, giving the maximum consecutive cycles one requester may hold a grant (legal range 1..255).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, reset; it is asynchronous and active-low.
REQ-004 The module SHALL have port req, input, 32 bits; req[k] is the request from requester k.
REQ-005 The module SHALL have port hold, input, 32 bits; hold[k] asks to keep an existing grant to requester k.
REQ-006 The module SHALL have port gnt_val, output, 1 bit; high while a grant is active.
REQ-007 The module SHALL have port gnt_idx, output, 5 bits; binary index of the granted requester.
REQ-008 The module SHALL have port gnt_onehot, output, 32 bits; MSB-first one-hot: index k drives bit 31-k, all zero when gnt_val is low.
REQ-009 The module SHALL have port busy, output, 1 bit; high when the FSM is in GRANT.

Function
REQ-010 All outputs SHALL be registered; a grant decided from inputs sampled at edge t SHALL be visible after edge t.
REQ-011 The FSM SHALL have two states, IDLE and GRANT; IDLE -> GRANT when any req bit is high; GRANT -> IDLE when the grant ends and no req bit is high.
REQ-012 Arbitration SHALL be round-robin: search starts at index (last_idx+1) mod 32, ascending with wrap 31 -> 0; first requester found wins.
REQ-013 last_idx SHALL update to the new winner on every new grant and SHALL reset to 31, so index 0 has top priority after reset.
REQ-014 A grant to k SHALL continue next cycle only if req[k] and hold[k] are both high and hold_cnt < MAX_HOLD-1; otherwise it ends.
REQ-015 hold_cnt SHALL be 0 on each new grant and increment by 1 each continued cycle; it SHALL never exceed MAX_HOLD-1.
REQ-016 When a grant ends and any req bit is high, a new round-robin grant SHALL issue on the same edge (back-to-back, no idle bubble).
REQ-017 On a forced release (hold_cnt limit), the previous owner SHALL have the lowest priority in the re-arbitration, even if still requesting.
REQ-018 If req[k] drops while k is granted, gnt_val SHALL go low, or pass to another requester, on the next edge.
REQ-019 hold bits of non-granted requesters SHALL be ignored; hold without req SHALL not create a grant.
REQ-020 gnt_onehot SHALL always equal the MSB-first decode of gnt_idx gated by gnt_val; gnt_idx SHALL hold its last value while gnt_val is low.
REQ-021 With MAX_HOLD = 1 every grant SHALL last exactly one cycle.

Reset
REQ-022 On rst_n low, immediately and regardless of clk: gnt_val=0, gnt_idx=0, gnt_onehot=0, busy=0, hold_cnt=0, last_idx=31, FSM=IDLE.
REQ-023 Reset asserted mid-grant SHALL abort the grant with no further cycle of gnt_val; after release, first arbitration SHALL start from index 0.

Verification
REQ-024 Reset, then req=all ones, hold=0 for 33 cycles -> gnt_idx 0,1,...,31,0; gnt_onehot 0x80000000, 0x40000000, ...; gnt_val continuous.
REQ-025 MAX_HOLD=4, req[5]=req[9]=1, hold[5]=1 -> index 5 granted 4 cycles, then 9 (1 cycle), then 5 again.
REQ-026 Only req[3]=1, hold[3]=1, drop req[3] after 2 granted cycles -> gnt_val low next edge, busy=0, gnt_onehot=0, gnt_idx stays 3.
REQ-027 After grant to 30, req bits 1 and 31 high -> next grant 31, then 1 (wrap).
REQ-028 rst_n pulsed low mid-grant to 12 -> outputs zero asynchronously; after release, req bits 0 and 12 high -> first grant 0.

Source files
------------

// File: rtl/arbiter_rr_32.sv
// -----------------------------------------------------------------------------
// arbiter_rr_32
//
// Round-robin arbiter for 32 requesters with optional grant holding.
//
// A requester that is granted may keep the grant for consecutive cycles by
// holding both its req and hold bits high. Holding is limited to MAX_HOLD
// cycles. After that the grant is forcibly released and re-arbitrated. The
// previous owner ranks last in that round.
// When a grant ends and other requests are pending, the next grant is issued on
// the same edge, so there is no idle bubble.
//
// Parameters
//   MAX_HOLD   : maximum consecutive cycles one requester may hold a grant
//                (1..255)
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   req        : req[k] is the request from requester k
//   hold       : hold[k] asks to keep an existing grant to requester k
//   gnt_val    : high while a grant is active (registered)
//   gnt_idx    : binary index of the granted requester (registered, holds its
//                last value while gnt_val is low)
//   gnt_onehot : MSB-first one-hot of gnt_idx, index k drives bit 31-k,
//                all zero while gnt_val is low (registered)
//   busy       : high while the FSM is in GRANT (registered)
// -----------------------------------------------------------------------------
module arbiter_rr_32 #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req,
  input  logic [31:0] hold,
  output logic        gnt_val,
  output logic [4:0]  gnt_idx,
  output logic [31:0] gnt_onehot,
  output logic        busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // The last continued cycle is the one where hold_cnt reaches MAX_HOLD-1.
  // With MAX_HOLD = 1 this limit is zero, so a grant can never be continued.
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  logic [0:0] state;
  logic [7:0] hold_cnt;
  logic [4:0] last_idx;

  logic [0:0] nxt_state;
  logic       nxt_val;
  logic [4:0] nxt_idx;
  logic [7:0] nxt_cnt;
  logic [4:0] nxt_last;

  logic       keep_grant;
  logic       any_req;
  logic [4:0] start;
  logic [31:0] rot_req;
  logic [4:0] offset;
  logic       found;
  logic [4:0] winner;

  // A grant continues only for its owner. The hold bits of other requesters
  // never take part in this decision.
  assign keep_grant = (state == GRANT) && req[gnt_idx] && hold[gnt_idx] &&
                      (hold_cnt < HOLD_LIMIT);
  assign any_req    = |req;

  // The search starts just after the last winner. This makes the last winner
  // the lowest priority, which also covers the forced-release case. The 5-bit
  // add wraps 31 -> 0 without extra logic.
  assign start = last_idx + 5'd1;

  // Rotate the request vector so that bit 0 is the first candidate.
  always_comb begin
    rot_req = '0;
    for (int j = 0; j < 32; j++) begin
      rot_req[j] = req[5'(start + 5'(j))];
    end
  end

  // Lowest set bit of the rotated vector gives the winner's distance from start.
  // NOTE: every combinational output gets a default before any branch;
  // a path that leaves a variable unassigned would infer a latch.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int j = 0; j < 32; j++) begin
      if (!found && rot_req[j]) begin
        found  = 1'b1;
        offset = 5'(j);
      end
    end
  end

  assign winner = start + offset;

  // Next-state decision: continue, re-arbitrate (back-to-back), or go idle.
  always_comb begin
    nxt_state = state;
    nxt_val   = gnt_val;
    nxt_idx   = gnt_idx;
    nxt_cnt   = hold_cnt;
    nxt_last  = last_idx;
    if (keep_grant) begin
      nxt_cnt = hold_cnt + 8'd1;
    end else if (any_req) begin
      nxt_state = GRANT;
      nxt_val   = 1'b1;
      nxt_idx   = winner;
      nxt_last  = winner;
      nxt_cnt   = '0;
    end else begin
      // gnt_idx is left alone on purpose: it keeps the last owner visible.
      nxt_state = IDLE;
      nxt_val   = 1'b0;
      nxt_cnt   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  // NOTE: last_idx resets to 31 rather than 0. This makes requester 0 the first
  // candidate after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_idx   <= 5'd31;
      gnt_val    <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt_state;
      hold_cnt   <= nxt_cnt;
      last_idx   <= nxt_last;
      gnt_val    <= nxt_val;
      gnt_idx    <= nxt_idx;
      gnt_onehot <= nxt_val ? (32'h8000_0000 >> nxt_idx) : 32'h0;
      busy       <= (nxt_state == GRANT);
    end
  end

endmodule
